// File: rtl/choose_stepper.sv
// choose_stepper: upstream selector for the LED result display.
// Steps a 2-bit page select on each debounced button press or, when enabled,
// automatically every AUTO_PERIOD cycles. A hold input freezes the select and
// the auto timer. step_pulse/wrap are registered strobes aligned with the new
// choose value.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   btn        - raw bouncy push button, asynchronous to clk
//   auto_en    - enable automatic stepping
//   hold       - freeze stepping and the auto timer
//   choose     - current 2-bit select
//   step_pulse - 1-cycle strobe in the first cycle of a new choose value
//   wrap       - 1-cycle strobe with step_pulse on the 11 -> 00 step
module choose_stepper #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned AUTO_PERIOD = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       auto_en,
  input  logic       hold,
  output logic [1:0] choose,
  output logic       step_pulse,
  output logic       wrap
);

  typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} deb_state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);

  logic             sync1, btn_s;
  deb_state_t       state;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] auto_cnt;
  logic             btn_db;
  logic             press;
  logic             tick;
  logic             req;

  // Two-flop synchroniser on the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
    end
  end

  // Debounce: a level change is accepted after DEB_CYCLES consecutive
  // samples that differ from btn_db. The stable states and the check states
  // share one transition rule, keyed on btn_s versus the current btn_db.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOW;
      deb_cnt <= '0;
      btn_db  <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        LOW, HIGH: begin
          if (btn_s != btn_db) begin
            if (DEB_CYCLES == 1) begin
              btn_db  <= ~btn_db;
              press   <= ~btn_db;
              state   <= btn_db ? LOW : HIGH;
              deb_cnt <= '0;
            end else begin
              state   <= btn_db ? CHK_LO : CHK_HI;
              deb_cnt <= CNT_W'(1);
            end
          end
        end
        CHK_HI, CHK_LO: begin
          if (btn_s == btn_db) begin
            state   <= btn_db ? HIGH : LOW;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            btn_db  <= ~btn_db;
            press   <= ~btn_db;
            state   <= btn_db ? LOW : HIGH;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= LOW;
          deb_cnt <= '0;
        end
      endcase
    end
  end

  assign tick = auto_en & ~hold & (auto_cnt == AUTO_LAST);
  assign req  = (press | tick) & ~hold;

  // Auto timer: frozen under hold, restarted by any step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if (!auto_en) begin
      auto_cnt <= '0;
    end else if (!hold) begin
      if (press || tick) auto_cnt <= '0;
      else               auto_cnt <= auto_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      choose     <= 2'b00;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      if (req) choose <= choose + 2'd1;
      step_pulse <= req;
      wrap       <= req & (choose == 2'b11);
    end
  end

endmodule

// File: tb/tb_choose_stepper.sv
module tb_choose_stepper;

  localparam int unsigned DEB = 4;
  localparam int unsigned AP  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       auto_en = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] choose;
  logic       step_pulse;
  logic       wrap;

  int asserts = 0;
  int fails   = 0;

  choose_stepper #(.DEB_CYCLES(DEB), .AUTO_PERIOD(AP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .btn(btn), .auto_en(auto_en), .hold(hold),
    .choose(choose), .step_pulse(step_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    asserts++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: button level is accepted once the last DEB synced
  // samples all disagree with the debounced level; auto steps every AP
  // enabled, unheld cycles; any step restarts the auto phase.
  bit       m_s1, m_s2;
  bit       hist[DEB];
  bit       nh[DEB];
  bit       m_db, m_press;
  int       m_phase;
  bit [1:0] m_choose;
  bit       m_sp, m_wr;
  bit       tick_m, req_m, all_diff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= 0; m_s2 <= 0; m_db <= 0; m_press <= 0;
      m_phase <= 0; m_choose <= 0; m_sp <= 0; m_wr <= 0;
      for (int i = 0; i < DEB; i++) hist[i] <= 0;
    end else begin
      tick_m = auto_en && !hold && (m_phase == AP - 1);
      req_m  = (m_press || tick_m) && !hold;
      if (req_m) m_choose <= m_choose + 2'd1;
      m_sp <= req_m;
      m_wr <= req_m && (m_choose == 2'd3);
      if (!auto_en) m_phase <= 0;
      else if (!hold) m_phase <= (m_press || tick_m) ? 0 : m_phase + 1;
      for (int i = DEB - 1; i > 0; i--) nh[i] = hist[i-1];
      nh[0] = m_s2;
      all_diff = 1;
      for (int i = 0; i < DEB; i++) if (nh[i] == m_db) all_diff = 0;
      if (all_diff) begin
        m_db    <= ~m_db;
        m_press <= ~m_db;
      end else begin
        m_press <= 0;
      end
      for (int i = 0; i < DEB; i++) hist[i] <= nh[i];
      m_s2 <= m_s1;
      m_s1 <= btn;
    end
  end

  always @(negedge clk) begin
    chk("model_choose", int'(choose), int'(m_choose));
    chk("model_step_pulse", int'(step_pulse), int'(m_sp));
    chk("model_wrap", int'(wrap), int'(m_wr));
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; btn = 0; auto_en = 0; hold = 0;
    @(negedge clk);
    rst = 0;
  endtask

  int spc;
  int lens[5] = '{3, 2, 3, 15, 0};
  int seg;

  initial begin
    // 1. async reset while choose = 10 and a strobe is high
    do_reset();
    @(negedge clk) auto_en = 1;
    repeat (16) @(negedge clk);
    chk("t1_choose_pre", int'(choose), 2);
    chk("t1_sp_pre", int'(step_pulse), 1);
    #2 rst = 1;
    #1;
    chk("t1_rst_choose", int'(choose), 0);
    chk("t1_rst_sp", int'(step_pulse), 0);
    chk("t1_rst_wrap", int'(wrap), 0);
    auto_en = 0;
    @(negedge clk) rst = 0;

    // 2. clean press, first sampled at edge N, step at N+6
    do_reset();
    @(negedge clk) btn = 1;
    spc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (step_pulse) spc++;
      if (i == 6) chk("t2_before", int'(choose), 0);
      if (i == 7) chk("t2_step", int'(choose), 1);
    end
    chk("t2_pulse_count", spc, 1);
    btn = 0;
    repeat (20) @(negedge clk);
    chk("t2_release", int'(choose), 1);

    // 3. bounce: runs shorter than DEB never accept
    do_reset();
    spc = 0;
    for (int s = 0; s < 4; s++) begin
      btn = (s % 2 == 0) && (s < 3);
      for (int j = 0; j < lens[s]; j++) begin
        @(negedge clk);
        if (step_pulse) spc++;
      end
    end
    chk("t3_choose", int'(choose), 0);
    chk("t3_pulses", spc, 0);

    // 4. auto stepping every 8 cycles, wrap on the 4th step
    do_reset();
    @(negedge clk) auto_en = 1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("t4_choose", int'(choose), (k / 8) % 4);
      chk("t4_sp", int'(step_pulse), int'(k % 8 == 0));
      chk("t4_wrap", int'(wrap), int'(k == 32));
    end
    auto_en = 0;

    // 5. hold at auto phase 5, press during hold is discarded
    do_reset();
    @(negedge clk) auto_en = 1;
    repeat (5) @(negedge clk);
    hold = 1;
    spc = 0;
    for (int i = 0; i < 22; i++) begin
      btn = (i < 10);
      @(negedge clk);
      if (step_pulse) spc++;
    end
    chk("t5_frozen", int'(choose), 0);
    chk("t5_pulses", spc, 0);
    hold = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t5_resume", int'(choose), int'(k == 3));
    end
    auto_en = 0;

    // 6a. press accepted on the same cycle as the auto tick
    do_reset();
    @(negedge clk) auto_en = 1;
    @(negedge clk) btn = 1;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      chk("t6_coinc", int'(choose), int'(k >= 8) + int'(k >= 16));
      if (k == 8) chk("t6_coinc_sp", int'(step_pulse), 1);
    end
    btn = 0; auto_en = 0;
    repeat (10) @(negedge clk);

    // 6b. reset mid-debounce with the button held
    do_reset();
    @(negedge clk) btn = 1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    @(negedge clk) rst = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("t6_rst_recover", int'(choose), int'(i == 7));
    end
    btn = 0;
    repeat (10) @(negedge clk);

    // Randomised run against the model
    seg = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (seg == 0) begin
        btn = ~btn;
        seg = $urandom_range(1, 12);
      end else begin
        seg--;
      end
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk);
        #3 rst = 1;
        @(negedge clk) rst = 0;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
